// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM states and fetch-stage constants.
// WORD_LEN normally comes from the project defines; fall back to 32 bits.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

package pipeline_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
// Ports: clk, rst_n (sync, active-low), inc (count enable), cnt (current value).
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Increment unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, fetches via a ready/valid imem handshake, freezes on
// hazard_detected, redirects and flushes on branch_taken, and keeps
// saturating stall/flush counters.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   hazard_detected                freeze PC and IF/ID
//   branch_taken, branch_addr      redirect fetch, flush IF/ID
//   imem_req, imem_addr            fetch request / address (= PC)
//   imem_valid, imem_rdata         fetched word valid / data
//   pc_ID, instr_ID, valid_ID      IF/ID register contents
//   stall_cnt, flush_cnt           performance counters
module if_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned WORD_LEN = `WORD_LEN,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hazard_detected,
  input  logic                branch_taken,
  input  logic [WORD_LEN-1:0] branch_addr,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_valid,
  input  logic [WORD_LEN-1:0] imem_rdata,
  output logic [WORD_LEN-1:0] pc_ID,
  output logic [WORD_LEN-1:0] instr_ID,
  output logic                valid_ID,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  fetch_state_t        state_q, state_d;
  logic [WORD_LEN-1:0] pc_q, pc_d;
  logic [WORD_LEN-1:0] pc_id_q, pc_id_d;
  logic [WORD_LEN-1:0] instr_id_q, instr_id_d;
  logic                valid_id_q, valid_id_d;
  logic [WORD_LEN-1:0] pc_plus4;
  logic                stall_inc;
  logic                flush_inc;

  // Next-state and IF/ID update; branch beats hazard beats fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_id_d    = pc_id_q;
    instr_id_d = instr_id_q;
    valid_id_d = valid_id_q;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    pc_plus4   = pc_q + WORD_LEN'(PC_STEP);

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (branch_taken) begin
          // Masking keeps the target word-aligned.
          pc_d       = branch_addr & ~WORD_LEN'(3);
          pc_id_d    = '0;
          instr_id_d = WORD_LEN'(NOP_INSTR);
          valid_id_d = 1'b0;
          flush_inc  = 1'b1;
        end else if (hazard_detected) begin
          stall_inc = 1'b1;
        end else if (imem_valid) begin
          pc_d       = pc_plus4;
          pc_id_d    = pc_plus4;
          instr_id_d = imem_rdata;
          valid_id_d = 1'b1;
        end else begin
          pc_id_d    = '0;
          instr_id_d = WORD_LEN'(NOP_INSTR);
          valid_id_d = 1'b0;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= '0;
      pc_id_q    <= '0;
      instr_id_q <= '0;
      valid_id_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_id_q    <= pc_id_d;
      instr_id_q <= instr_id_d;
      valid_id_q <= valid_id_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .cnt   (flush_cnt)
  );

  assign imem_req  = (state_q == RUN);
  assign imem_addr = pc_q;
  assign pc_ID     = pc_id_q;
  assign instr_ID  = instr_id_q;
  assign valid_ID  = valid_id_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage; a second instance with 2-bit
// counters shares the stimulus to exercise counter saturation.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        hazard_detected;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  logic        imem_req,  s_imem_req;
  logic [31:0] imem_addr, s_imem_addr;
  logic [31:0] pc_ID,     s_pc_ID;
  logic [31:0] instr_ID,  s_instr_ID;
  logic        valid_ID,  s_valid_ID;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int checks;
  int errors;

  if_stage #(.WORD_LEN(32), .CNT_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hazard_detected (hazard_detected),
    .branch_taken    (branch_taken),
    .branch_addr     (branch_addr),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_valid      (imem_valid),
    .imem_rdata      (imem_rdata),
    .pc_ID           (pc_ID),
    .instr_ID        (instr_ID),
    .valid_ID        (valid_ID),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  if_stage #(.WORD_LEN(32), .CNT_W(2)) dut_s (
    .clk             (clk),
    .rst_n           (rst_n),
    .hazard_detected (hazard_detected),
    .branch_taken    (branch_taken),
    .branch_addr     (branch_addr),
    .imem_req        (s_imem_req),
    .imem_addr       (s_imem_addr),
    .imem_valid      (imem_valid),
    .imem_rdata      (imem_rdata),
    .pc_ID           (s_pc_ID),
    .instr_ID        (s_instr_ID),
    .valid_ID        (s_valid_ID),
    .stall_cnt       (s_stall_cnt),
    .flush_cnt       (s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        hz;
    logic        br;
    logic [31:0] baddr;
    logic        iv;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc_id;
    logic [31:0] instr;
    logic        vld;
    int          stall;
    int          flush;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic hz, input logic br, input logic [31:0] ba,
                     input logic iv, input logic [31:0] rd, input logic req,
                     input logic [31:0] addr, input logic [31:0] pcid, input logic [31:0] ins,
                     input logic vld, input int st, input int fl);
    vec_t v;
    v.rst_n = r;  v.hz = hz;  v.br = br;  v.baddr = ba;  v.iv = iv;  v.rdata = rd;
    v.req = req;  v.addr = addr;  v.pc_id = pcid;  v.instr = ins;  v.vld = vld;
    v.stall = st;  v.flush = fl;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic int sat3(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  task automatic drive(input logic r, input logic hz, input logic br, input logic [31:0] ba,
                       input logic iv, input logic [31:0] rd);
    @(negedge clk);
    rst_n = r;  hazard_detected = hz;  branch_taken = br;
    branch_addr = ba;  imem_valid = iv;  imem_rdata = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                         input logic [31:0] pcid, input logic [31:0] ins, input logic vld,
                         input int st, input int fl);
    chk({tag, ".req"},      32'(imem_req),    32'(req));
    chk({tag, ".addr"},     imem_addr,        addr);
    chk({tag, ".pc_ID"},    pc_ID,            pcid);
    chk({tag, ".instr_ID"}, instr_ID,         ins);
    chk({tag, ".valid_ID"}, 32'(valid_ID),    32'(vld));
    chk({tag, ".stall"},    32'(stall_cnt),   32'(st));
    chk({tag, ".flush"},    32'(flush_cnt),   32'(fl));
    chk({tag, ".s_stall"},  32'(s_stall_cnt), 32'(sat3(st)));
    chk({tag, ".s_flush"},  32'(s_flush_cnt), 32'(sat3(fl)));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;  hazard_detected = 1'b0;  branch_taken = 1'b0;
    branch_addr = '0;  imem_valid = 1'b0;  imem_rdata = '0;

    //   rst hz br baddr          iv rdata          req addr           pc_ID          instr          v  st fl
    // reset held 3 cycles; branch/hazard during reset are overridden
    add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         32'h0,         0, 0, 0);
    add(0, 1, 1, 32'h40,        1, 32'h1234_5678, 0, 32'h0,         32'h0,         32'h0,         0, 0, 0);
    add(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         32'h0,         0, 0, 0);
    // BOOT cycle ignores imem_valid, then RUN
    add(1, 0, 0, 32'h0,         1, 32'hAAAA_AAAA, 1, 32'h0,         32'h0,         32'h0,         0, 0, 0);
    // streaming
    add(1, 0, 0, 32'h0,         1, 32'hE082_1004, 1, 32'h4,         32'h4,         32'hE082_1004, 1, 0, 0);
    add(1, 0, 0, 32'h0,         1, 32'hE081_1004, 1, 32'h8,         32'h8,         32'hE081_1004, 1, 0, 0);
    add(1, 0, 0, 32'h0,         1, 32'hE082_2001, 1, 32'hC,         32'hC,         32'hE082_2001, 1, 0, 0);
    // hazard freeze, imem_valid ignored
    add(1, 1, 0, 32'h0,         1, 32'h5555_5555, 1, 32'hC,         32'hC,         32'hE082_2001, 1, 1, 0);
    add(1, 1, 0, 32'h0,         1, 32'h6666_6666, 1, 32'hC,         32'hC,         32'hE082_2001, 1, 2, 0);
    // branch beats hazard; target aligned
    add(1, 1, 1, 32'h153,       1, 32'h7777_7777, 1, 32'h150,       32'h0,         32'h0,         0, 2, 1);
    add(1, 0, 0, 32'h0,         1, 32'h1111_1111, 1, 32'h154,       32'h154,       32'h1111_1111, 1, 2, 1);
    // memory wait gives bubble, address stable
    add(1, 0, 0, 32'h0,         0, 32'h2222_2222, 1, 32'h154,       32'h0,         32'h0,         0, 2, 1);
    // redirect to top of address space, wait, then wrap
    add(1, 0, 1, 32'hFFFF_FFFF, 0, 32'h0,         1, 32'hFFFF_FFFC, 32'h0,         32'h0,         0, 2, 2);
    add(1, 0, 0, 32'h0,         0, 32'h0,         1, 32'hFFFF_FFFC, 32'h0,         32'h0,         0, 2, 2);
    add(1, 0, 0, 32'h0,         0, 32'h0,         1, 32'hFFFF_FFFC, 32'h0,         32'h0,         0, 2, 2);
    add(1, 0, 0, 32'h0,         1, 32'hDEAD_BEEF, 1, 32'h0,         32'h0,         32'hDEAD_BEEF, 1, 2, 2);
    // more stalls: small instance saturates at 3
    add(1, 1, 0, 32'h0,         1, 32'h0,         1, 32'h0,         32'h0,         32'hDEAD_BEEF, 1, 3, 2);
    add(1, 1, 0, 32'h0,         0, 32'h0,         1, 32'h0,         32'h0,         32'hDEAD_BEEF, 1, 4, 2);
    add(1, 1, 0, 32'h0,         1, 32'h0,         1, 32'h0,         32'h0,         32'hDEAD_BEEF, 1, 5, 2);
    // reset in mid-stall clears everything
    add(0, 1, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0,         32'h0,         0, 0, 0);
    add(1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0,         32'h0,         32'h0,         0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].hz, vecs[i].br, vecs[i].baddr, vecs[i].iv, vecs[i].rdata);
      chk_all($sformatf("v%0d", i), vecs[i].req, vecs[i].addr, vecs[i].pc_id,
              vecs[i].instr, vecs[i].vld, vecs[i].stall, vecs[i].flush);
    end

    // Back-to-back branches: each redirects, flush counter saturates in small instance
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b0, 1'b1, 32'(k * 64 + 1), 1'b1, 32'hCAFE_0000);
      chk_all($sformatf("br%0d", k), 1'b1, 32'(k * 64), 32'h0, 32'h0, 1'b0, 0, k);
    end

    // Sustained fetch after the last branch target 0x100
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hF000_0000 + 32'(k));
      chk_all($sformatf("st%0d", k), 1'b1, 32'h104 + 32'(4 * k), 32'h104 + 32'(4 * k),
              32'hF000_0000 + 32'(k), 1'b1, 0, 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
